// File: rtl/ser_tx_pkg.sv
// Shared types and constants for the NRZ serial transmitter.
// State encodings, parity modes and the counter width helper.
package ser_tx_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Width for a counter holding 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ser_tx_bit_timer.sv
// Loadable down-counter that paces each serial bit for DIV cycles.
// Reloads DIV-1 on load and stops at zero.
module ser_tx_bit_timer
    import ser_tx_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic C,
    input  logic R,
    input  logic load,
    input  logic enable,
    output logic zero
);

    localparam int W = cnt_w(DIV);
    localparam logic [W-1:0] RELOAD = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ser_tx_nrz.sv
// Framed NRZ transmitter: start bit, data LSB-first, optional parity, stop.
// Every line level comes straight from a flop so the pad never glitches.
module ser_tx_nrz
    import ser_tx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV    = 4,
    parameter int PARITY = 0
) (
    input  logic              C,
    input  logic              R,
    input  logic [DATA_W-1:0] D,
    input  logic              LOAD_VALID,
    output logic              LOAD_READY,
    output logic              TXD,
    output logic              BUSY,
    output logic              DONE
);

    localparam int  IW     = cnt_w(DATA_W);
    localparam bit  PAR_ON = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    logic [2:0]        state;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] sh_nx;
    logic [IW-1:0]     idx;
    logic              par_bit;
    logic              par_nx;
    logic              txd_q;
    logic              done_q;
    logic              zero;
    logic              accept;
    logic              tick;
    logic              tmr_load;
    logic              tmr_en;

    assign LOAD_READY = (state == S_IDLE)
                     || ((state == S_STOP) && zero);
    assign accept     = LOAD_VALID && LOAD_READY;
    assign tick       = (state != S_IDLE) && zero;
    assign sh_nx      = sh >> 1;
    assign par_nx     = (PARITY == PAR_ODD) ? ~(^D) : (^D);

    // Leaving STOP for IDLE keeps the timer parked at zero.
    assign tmr_load = accept || (tick && (state != S_STOP));
    assign tmr_en   = (state != S_IDLE);

    ser_tx_bit_timer #(
        .DIV(DIV)
    ) u_timer (
        .C      (C),
        .R      (R),
        .load   (tmr_load),
        .enable (tmr_en),
        .zero   (zero)
    );

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state   <= S_IDLE;
            sh      <= '0;
            idx     <= '0;
            par_bit <= 1'b0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= tick && (state == S_STOP);
            if (accept) begin
                sh      <= D;
                par_bit <= par_nx;
                idx     <= '0;
                state   <= S_START;
                txd_q   <= 1'b0;
            end else if (tick) begin
                unique case (state)
                    S_START: begin
                        state <= S_DATA;
                        idx   <= '0;
                        txd_q <= sh[0];
                    end
                    S_DATA: begin
                        if (idx == LAST_IDX) begin
                            if (PAR_ON) begin
                                state <= S_PAR;
                                txd_q <= par_bit;
                            end else begin
                                state <= S_STOP;
                                txd_q <= 1'b1;
                            end
                        end else begin
                            idx   <= idx + IW'(1);
                            sh    <= sh_nx;
                            txd_q <= sh_nx[0];
                        end
                    end
                    S_PAR: begin
                        state <= S_STOP;
                        txd_q <= 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                        txd_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign TXD  = txd_q;
    assign DONE = done_q;
    assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_ser_tx_nrz.sv
// Bench for ser_tx_nrz: four instances cover the DIV/PARITY variants.
// Expected line levels come from a frame-bit model, not the RTL.
module tb_ser_tx_nrz;

    localparam int N = 4;
    localparam int DIVS [N] = '{4, 1, 1, 2};
    localparam int PARS [N] = '{0, 1, 2, 0};

    logic       C = 1'b0;
    logic       R = 1'b1;
    logic [7:0] d    [N];
    logic       lv   [N];
    logic       rdy  [N];
    logic       txd  [N];
    logic       busy [N];
    logic       done [N];

    int checks = 0;
    int errors = 0;

    always #5 C = ~C;

    ser_tx_nrz #(.DATA_W(8), .DIV(4), .PARITY(0)) u0 (
        .C(C), .R(R), .D(d[0]), .LOAD_VALID(lv[0]),
        .LOAD_READY(rdy[0]), .TXD(txd[0]), .BUSY(busy[0]), .DONE(done[0])
    );
    ser_tx_nrz #(.DATA_W(8), .DIV(1), .PARITY(1)) u1 (
        .C(C), .R(R), .D(d[1]), .LOAD_VALID(lv[1]),
        .LOAD_READY(rdy[1]), .TXD(txd[1]), .BUSY(busy[1]), .DONE(done[1])
    );
    ser_tx_nrz #(.DATA_W(8), .DIV(1), .PARITY(2)) u2 (
        .C(C), .R(R), .D(d[2]), .LOAD_VALID(lv[2]),
        .LOAD_READY(rdy[2]), .TXD(txd[2]), .BUSY(busy[2]), .DONE(done[2])
    );
    ser_tx_nrz #(.DATA_W(8), .DIV(2), .PARITY(0)) u3 (
        .C(C), .R(R), .D(d[3]), .LOAD_VALID(lv[3]),
        .LOAD_READY(rdy[3]), .TXD(txd[3]), .BUSY(busy[3]), .DONE(done[3])
    );

    // Frame bit j: 0 start, 1..8 data LSB first, then parity if any, then stop.
    function automatic logic exp_bit(input logic [7:0] w, input int par, input int j);
        int ones;
        ones = $countones(w);
        if (j == 0) return 1'b0;
        if (j <= 8) return w[j-1];
        if (j == 9 && par == 1) return (ones % 2) == 1;
        if (j == 9 && par == 2) return (ones % 2) == 0;
        return 1'b1;
    endfunction

    function automatic int frame_len(input int k);
        return (10 + ((PARS[k] != 0) ? 1 : 0)) * DIVS[k];
    endfunction

    task automatic test_reset();
        #2 R = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge C);
            for (int k = 0; k < N; k++) begin
                checks++;
                if ({txd[k], busy[k], done[k], rdy[k]} !== 4'b1001) begin
                    errors++;
                    $display("FAIL reset_hold dut%0d: got txd/busy/done/rdy %b%b%b%b want 1001",
                             k, txd[k], busy[k], done[k], rdy[k]);
                end
            end
        end
        R = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge C);
            for (int k = 0; k < N; k++) begin
                checks++;
                if ({txd[k], busy[k], done[k], rdy[k]} !== 4'b1001) begin
                    errors++;
                    $display("FAIL idle dut%0d cyc %0d: got txd/busy/done/rdy %b%b%b%b want 1001",
                             k, c, txd[k], busy[k], done[k], rdy[k]);
                end
            end
        end
    endtask

    // Sends one word from an idle instance and follows the whole frame.
    task automatic test_frame(input int k, input logic [7:0] w,
                              input bit noise, input string tag);
        int   len;
        logic e;
        len   = frame_len(k);
        d[k]  = w;
        lv[k] = 1'b1;
        @(negedge C);
        for (int i = 0; i < len; i++) begin
            e = exp_bit(w, PARS[k], i / DIVS[k]);
            checks++;
            if (txd[k] !== e) begin
                errors++;
                $display("FAIL %s txd dut%0d cyc %0d: got %b want %b", tag, k, i, txd[k], e);
            end
            checks++;
            if ({busy[k], done[k], rdy[k]} !== {2'b10, i == len - 1}) begin
                errors++;
                $display("FAIL %s flags dut%0d cyc %0d: got busy/done/rdy %b%b%b want 10%b",
                         tag, k, i, busy[k], done[k], rdy[k], i == len - 1);
            end
            if (noise && i < len - 1) begin
                lv[k] = 1'($urandom_range(0, 1));
                d[k]  = 8'($urandom);
            end else begin
                lv[k] = 1'b0;
            end
            @(negedge C);
        end
        checks++;
        if ({txd[k], busy[k], done[k], rdy[k]} !== 4'b1011) begin
            errors++;
            $display("FAIL %s end dut%0d: got txd/busy/done/rdy %b%b%b%b want 1011",
                     tag, k, txd[k], busy[k], done[k], rdy[k]);
        end
        @(negedge C);
        checks++;
        if (done[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse dut%0d: got %b want 0", tag, k, done[k]);
        end
    endtask

    task automatic test_basic();
        test_frame(0, 8'hA5, 1'b0, "basic");
    endtask

    task automatic test_parity();
        test_frame(1, 8'hA5, 1'b0, "par_even_a5");
        test_frame(2, 8'hA5, 1'b0, "par_odd_a5");
        test_frame(1, 8'h01, 1'b0, "par_even_01");
        test_frame(2, 8'h01, 1'b0, "par_odd_01");
    endtask

    task automatic test_back_to_back();
        int         len;
        logic [7:0] w;
        logic       e;
        len   = frame_len(3);
        d[3]  = 8'h0F;
        lv[3] = 1'b1;
        @(negedge C);
        d[3] = 8'hF0;
        for (int i = 0; i < 2 * len; i++) begin
            w = (i < len) ? 8'h0F : 8'hF0;
            e = exp_bit(w, 0, (i % len) / DIVS[3]);
            checks++;
            if (txd[3] !== e) begin
                errors++;
                $display("FAIL b2b txd cyc %0d: got %b want %b", i, txd[3], e);
            end
            checks++;
            if ({busy[3], done[3], rdy[3]} !==
                {1'b1, i == len, (i == len - 1) || (i == 2 * len - 1)}) begin
                errors++;
                $display("FAIL b2b flags cyc %0d: got busy/done/rdy %b%b%b", i,
                         busy[3], done[3], rdy[3]);
            end
            if (i == len) lv[3] = 1'b0;
            @(negedge C);
        end
        checks++;
        if ({txd[3], busy[3], done[3]} !== 3'b101) begin
            errors++;
            $display("FAIL b2b end: got txd/busy/done %b%b%b want 101",
                     txd[3], busy[3], done[3]);
        end
        @(negedge C);
    endtask

    task automatic test_reset_mid();
        d[0]  = 8'h00;
        lv[0] = 1'b1;
        @(negedge C);
        lv[0] = 1'b0;
        for (int i = 0; i < 13; i++) begin
            checks++;
            if ({txd[0], done[0]} !== 2'b00) begin
                errors++;
                $display("FAIL rst_mid pre cyc %0d: got txd/done %b%b want 00",
                         i, txd[0], done[0]);
            end
            @(negedge C);
        end
        #1 R = 1'b0;
        #1;
        checks++;
        if ({txd[0], busy[0], done[0], rdy[0]} !== 4'b1001) begin
            errors++;
            $display("FAIL rst_mid async: got txd/busy/done/rdy %b%b%b%b want 1001",
                     txd[0], busy[0], done[0], rdy[0]);
        end
        @(negedge C);
        R = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge C);
            checks++;
            if ({txd[0], busy[0], done[0]} !== 3'b100) begin
                errors++;
                $display("FAIL rst_mid after cyc %0d: got txd/busy/done %b%b%b want 100",
                         c, txd[0], busy[0], done[0]);
            end
        end
        test_frame(0, 8'hFF, 1'b0, "rst_mid_ff");
    endtask

    task automatic test_busy_ignore();
        for (int n = 0; n < 3; n++) begin
            test_frame(0, 8'($urandom), 1'b1, "busy_ign4");
            test_frame(1, 8'($urandom), 1'b1, "busy_ign1");
            test_frame(3, 8'($urandom), 1'b1, "busy_ign2");
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < N; k++) begin
                repeat ($urandom_range(0, 3)) @(negedge C);
                test_frame(k, 8'($urandom), 1'($urandom_range(0, 1)), "rand");
            end
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            d[k]  = 8'h00;
            lv[k] = 1'b0;
        end
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_reset_mid();
        test_busy_ignore();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
